// File: rtl/attn_softmax.sv
// attn_softmax: grouped int8 softmax, shift-based exponent, serial divider.
// Define SOFTMAX_ROUND_EN to round weights to nearest instead of truncating.
module attn_softmax #(
  parameter int N_ELEM      = 4,
  parameter int SCALE_SHIFT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_vld,
  output logic       s_rdy,
  output logic [7:0] m_data,
  output logic       m_vld,
  input  logic       m_rdy,
  output logic       m_last,
  output logic       busy
);

  localparam int IW = (N_ELEM > 2) ? $clog2(N_ELEM) : 1;
  localparam int SW = $clog2(N_ELEM * 128 + 1);
  localparam int WW = SW + 9;

  typedef enum logic [1:0] {
    COLLECT,
    EXP,
    DIV,
    OUT
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic signed [7:0] max_q, max_d;
  logic [SW-1:0]     sum_q, sum_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [WW-1:0]     rem_q, rem_d;
  logic [7:0]        quo_q, quo_d;
  logic              sat_q, sat_d;
  logic [7:0]        mdat_q, mdat_d;
  logic [7:0]        buf_q [N_ELEM];

  logic              buf_we;
  logic [7:0]        buf_wd;
  logic              last;
  logic [7:0]        cur;
  logic [8:0]        diff;
  logic [8:0]        shd;
  logic [3:0]        k;
  logic [7:0]        e;
  logic [WW-1:0]     rnd;
  logic [WW-1:0]     num;
  logic [WW-1:0]     dsh;
  logic [WW-1:0]     trial;
  logic              ge;

  assign last = (idx_q == IW'(N_ELEM - 1));
  assign cur  = buf_q[idx_q];

  // Scores are sign-extended so max - s_i spans 0..255.
  assign diff = {max_q[7], max_q} - {cur[7], cur};
  assign shd  = diff >> SCALE_SHIFT;
  assign k    = (shd > 9'd8) ? 4'd8 : shd[3:0];
  assign e    = 8'd128 >> k;

`ifdef SOFTMAX_ROUND_EN
  assign rnd = WW'(sum_q >> 1);
`else
  assign rnd = '0;
`endif

  assign num   = (WW'(cur) << 8) - WW'(cur) + rnd;
  assign dsh   = WW'(sum_q) << (4'd8 - cnt_q);
  assign ge    = (rem_q >= dsh);
  assign trial = rem_q - dsh;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    max_d   = max_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    sat_d   = sat_q;
    mdat_d  = mdat_q;
    buf_we  = 1'b0;
    buf_wd  = s_data;
    unique case (state_q)
      COLLECT: begin
        if (s_vld) begin
          buf_we = 1'b1;
          if (idx_q == '0 || $signed(s_data) > max_q)
            max_d = $signed(s_data);
          if (last) begin
            idx_d   = '0;
            state_d = EXP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      EXP: begin
        buf_we = 1'b1;
        buf_wd = e;
        sum_d  = sum_q + SW'(e);
        if (last) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = DIV;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DIV: begin
        if (cnt_q == 4'd0) begin
          rem_d = num;
          sat_d = (num >= (WW'(sum_q) << 8));
          quo_d = '0;
          cnt_d = 4'd1;
        end else begin
          if (ge)
            rem_d = trial;
          quo_d = {quo_q[6:0], ge};
          if (cnt_q == 4'd8) begin
            mdat_d  = sat_q ? 8'hff : {quo_q[6:0], ge};
            cnt_d   = '0;
            state_d = OUT;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      OUT: begin
        if (m_rdy) begin
          if (last) begin
            idx_d   = '0;
            max_d   = '0;
            sum_d   = '0;
            state_d = COLLECT;
          end else begin
            idx_d   = idx_q + IW'(1);
            cnt_d   = '0;
            state_d = DIV;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      max_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      sat_q   <= 1'b0;
      mdat_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      sat_q   <= sat_d;
      mdat_q  <= mdat_d;
    end
  end

  // Slots hold raw scores in COLLECT, then are overwritten with e_i in EXP.
  always_ff @(posedge clk) begin
    if (buf_we)
      buf_q[idx_q] <= buf_wd;
  end

  assign s_rdy  = (state_q == COLLECT);
  assign busy   = (state_q != COLLECT);
  assign m_vld  = (state_q == OUT);
  assign m_last = (state_q == OUT) && last;
  assign m_data = mdat_q;

endmodule

// File: tb/tb_attn_softmax.sv
// tb_attn_softmax: directed groups, scoreboard queue, negedge monitor.
// Covers latency, stall hold, mid-group reset and back-to-back groups.
module tb_attn_softmax;

  localparam int N = 4;

  typedef logic [7:0] vec_t [N];
  typedef struct {
    logic [7:0] d;
    logic       last;
    logic       first;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_vld = 1'b0;
  logic       s_rdy;
  logic [7:0] m_data;
  logic       m_vld;
  logic       m_rdy = 1'b1;
  logic       m_last;
  logic       busy;

  attn_softmax #(
    .N_ELEM(N),
    .SCALE_SHIFT(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_data(s_data),
    .s_vld(s_vld),
    .s_rdy(s_rdy),
    .m_data(m_data),
    .m_vld(m_vld),
    .m_rdy(m_rdy),
    .m_last(m_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: condition not met", name);
  endtask

  int         acc_cnt = 0;
  int         acc_edge = 0;
  int         hs_edge = 0;
  logic       vld_p = 1'b0;
  logic       rdy_p = 1'b1;
  logic       last_p = 1'b0;
  logic [7:0] dat_p = '0;

  always @(negedge clk) begin
    exp_t x;
    if (!rst_n) begin
      acc_cnt = 0;
      vld_p   = 1'b0;
      rdy_p   = 1'b1;
    end else begin
      if (m_vld && !vld_p) begin
        if (sb.size() == 0)
          fail("unexpected_vld");
        else if (sb[0].first)
          chk("lat_first", cyc - acc_edge, N + 9);
        else
          chk("lat_next", cyc - hs_edge, 9);
      end
      if (m_vld && vld_p && !rdy_p) begin
        chk("hold_data", m_data, dat_p);
        chk("hold_last", m_last, last_p);
      end
      if (m_vld)
        chk("s_rdy_in_out", s_rdy, 0);
      if (m_last && !m_vld)
        fail("last_without_vld");
      if (m_vld && m_rdy && sb.size() > 0) begin
        x = sb.pop_front();
        chk("weight", m_data, x.d);
        chk("m_last", m_last, x.last);
        hs_edge = cyc + 1;
      end
      if (s_vld && s_rdy) begin
        acc_cnt++;
        if (acc_cnt == N) begin
          acc_cnt  = 0;
          acc_edge = cyc + 1;
        end
      end
      vld_p  = m_vld;
      rdy_p  = m_rdy;
      dat_p  = m_data;
      last_p = m_last;
    end
  end

  task automatic push_group(input vec_t w);
    exp_t x;
    for (int i = 0; i < N; i++) begin
      x.d     = w[i];
      x.last  = (i == N - 1);
      x.first = (i == 0);
      sb.push_back(x);
    end
  endtask

  task automatic send(input logic [7:0] v);
    int n;
    n = 0;
    s_data = v;
    s_vld  = 1'b1;
    forever begin
      @(negedge clk);
      if (s_rdy) break;
      n++;
      if (n > 1000) begin
        fail("send_timeout");
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_group(input vec_t sc, input vec_t w, input bit hold);
    push_group(w);
    for (int i = 0; i < N; i++) send(sc[i]);
    if (!hold) s_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  vec_t sc_eq  = '{8'd10, 8'd10, 8'd10, 8'd10};
  vec_t sc_mix = '{8'd8, 8'd4, 8'd0, 8'h80};
  vec_t sc_hi  = '{8'd40, 8'd0, 8'd0, 8'd0};
  vec_t sc_lo  = '{8'h80, 8'h80, 8'h80, 8'd127};
`ifdef SOFTMAX_ROUND_EN
  vec_t w_eq   = '{8'd64, 8'd64, 8'd64, 8'd64};
  vec_t w_mix  = '{8'd146, 8'd73, 8'd36, 8'd0};
`else
  vec_t w_eq   = '{8'd63, 8'd63, 8'd63, 8'd63};
  vec_t w_mix  = '{8'd145, 8'd72, 8'd36, 8'd0};
`endif
  vec_t w_hi   = '{8'd255, 8'd0, 8'd0, 8'd0};
  vec_t w_lo   = '{8'd0, 8'd0, 8'd0, 8'd255};

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_vld", m_vld, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_s_rdy", s_rdy, 1);
    @(posedge clk);
    #1;

    send_group(sc_eq, w_eq, 1'b0);
    chk("busy_after_group", busy, 1);
    drain();
    send_group(sc_mix, w_mix, 1'b0);
    drain();
    send_group(sc_hi, w_hi, 1'b0);
    drain();
    send_group(sc_lo, w_lo, 1'b0);
    drain();

    m_rdy = 1'b0;
    send_group(sc_mix, w_mix, 1'b0);
    n = 0;
    while (!m_vld && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) fail("stall_wait_timeout");
    repeat (20) @(posedge clk);
    #1;
    m_rdy = 1'b1;
    drain();

    send_group(sc_mix, w_mix, 1'b0);
    n = 0;
    while (sb.size() != N - 1 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) fail("first_weight_timeout");
    repeat (3) @(posedge clk);
    #1;
    chk("in_div_busy", busy, 1);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_rst_m_vld", m_vld, 0);
    chk("mid_rst_s_rdy", s_rdy, 1);
    chk("mid_rst_busy", busy, 0);
    send_group(sc_eq, w_eq, 1'b0);
    drain();

    send_group(sc_hi, w_hi, 1'b1);
    send_group(sc_lo, w_lo, 1'b1);
    send_group(sc_mix, w_mix, 1'b0);
    drain();

    repeat (12) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    chk("idle_m_vld", m_vld, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/attn_softmax.md
ATTN_SOFTMAX -- requirements
Module: attn_softmax

Interface
REQ-001 Parameter N_ELEM, default 4, number of scores per softmax group (2..8).
REQ-002 Parameter SCALE_SHIFT, default 2, right shift applied to (max - score) before exponent lookup.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 s_data  input  8  signed score from upstream MAC stage.
REQ-006 s_vld  input  1  s_data valid.
REQ-007 s_rdy  output  1  block accepts a score this cycle.
REQ-008 m_data  output  8  unsigned attention weight, 255 represents 1.0.
REQ-009 m_vld  output  1  m_data valid.
REQ-010 m_rdy  input  1  downstream accepts m_data.
REQ-011 m_last  output  1  high with m_vld on the final weight of a group.
REQ-012 busy  output  1  high in any state other than COLLECT.

Function
REQ-013 The FSM SHALL have states COLLECT, EXP, DIV and OUT; s_rdy SHALL be high only in COLLECT.
REQ-014 In COLLECT, each cycle with s_vld&&s_rdy SHALL store s_data into buffer slot idx, update running signed max (first score of a group loads max unconditionally) and increment idx.
REQ-015 On acceptance of score N_ELEM-1 the FSM SHALL enter EXP next cycle with idx cleared.
REQ-016 EXP SHALL spend exactly one cycle per element: d=max-s_i (9-bit unsigned, 0..255), k=min(d>>SCALE_SHIFT,8), e_i=128>>k (8-bit), e_i stored, sum+=e_i.
REQ-017 sum SHALL be clog2(N_ELEM*128+1) bits wide, never overflows, and is always >=128 (max element yields 128).
REQ-018 After N_ELEM EXP cycles the FSM SHALL enter DIV for element 0.
REQ-019 DIV SHALL be a restoring divider producing one quotient bit per cycle, exactly 8 cycles, computing q=floor(num/sum), num=e_i*255.
REQ-020 Quotient SHALL saturate to 255; after the 8th DIV cycle the FSM SHALL enter OUT with m_data=q, m_vld=1.
REQ-021 First m_vld SHALL rise N_ELEM+9 cycles after the clock edge accepting the last score.
REQ-022 In OUT, m_data, m_last and m_vld SHALL hold stable while m_rdy=0.
REQ-023 On m_vld&&m_rdy: if element < N_ELEM-1, go to DIV for next element (next m_vld 9 cycles later); else clear max, sum, idx and return to COLLECT.
REQ-024 m_last SHALL be 1 only in OUT for element N_ELEM-1.
REQ-025 Weights SHALL be emitted in the same order as scores were accepted.
REQ-026 s_vld while s_rdy=0 SHALL be ignored without state change; s_data is not sampled.
REQ-027 A score equal to the group max (including ties) SHALL yield e_i=128; d saturating to k=8 SHALL yield e_i=0.

Reset
REQ-028 While rst_n=0 at a clock edge: FSM=COLLECT, idx, max, sum, divider state=0, m_vld=0, m_data=0, m_last=0, busy=0, s_rdy=1 after release.
REQ-029 Reset in any state SHALL discard the partial or in-flight group; no weight from it is emitted after reset.

Configuration
REQ-030 Macro SOFTMAX_ROUND_EN: when defined, num=e_i*255+(sum>>1) (round to nearest); when undefined, num=e_i*255 (truncate); latency and interface unchanged.

Verification
REQ-031 Scores [10,10,10,10] -> weights 63,63,63,63 (64 each with SOFTMAX_ROUND_EN); m_last on 4th only.
REQ-032 Scores [8,4,0,-128], SCALE_SHIFT=2 -> 145,72,36,0 truncated; 146,73,36,0 with SOFTMAX_ROUND_EN.
REQ-033 Scores [40,0,0,0] -> 255,0,0,0; scores [-128,-128,-128,127] -> 0,0,0,255.
REQ-034 m_rdy held 0 for 20 cycles in OUT -> m_data/m_vld stable, s_rdy=0 throughout; release -> remaining weights follow at 9-cycle spacing.
REQ-035 rst_n pulsed low during DIV of element 1 -> m_vld=0 next cycle, s_rdy=1, fresh group [10,10,10,10] yields 63 x4.
REQ-036 Back-to-back groups with s_vld constantly high -> exactly N_ELEM accepts per group, first m_vld at N_ELEM+9 cycles after last accept, no cross-group max/sum leakage.
